// File: rtl/eoc_monitor_pkg.sv
// Shared types and constants for the multi-channel end-of-computation monitor.
// No logic here; latency/backpressure defined by the users of these types.
package iguana_eoc_pkg;

  typedef enum logic [1:0] {
    EocIdle    = 2'd0,
    EocRun     = 2'd1,
    EocDone    = 2'd2,
    EocTimeout = 2'd3
  } eoc_state_e;

  localparam logic EocModeAll = 1'b0;
  localparam logic EocModeAny = 1'b1;

  localparam int DoneBit = 0;

endpackage

// File: rtl/eoc_monitor_if.sv
// Control, write-stream and status bundle of the EOC monitor.
// Strobe-only write stream: no backpressure, every write is seen in the cycle it is valid.
interface eoc_monitor_if #(
  parameter int NumChannels = 4,
  parameter int DataWidth   = 32,
  parameter int CntWidth    = 32,
  parameter int ChIdxWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1
);

  logic                                 arm_i;
  logic                                 mode_i;
  logic [NumChannels-1:0]               chan_en_i;
  logic [CntWidth-1:0]                  timeout_i;
  logic [NumChannels-1:0]               wr_valid_i;
  logic [NumChannels*DataWidth-1:0]     wr_data_i;

  logic                                 busy_o;
  logic                                 done_o;
  logic                                 timeout_o;
  logic                                 pass_o;
  logic [NumChannels-1:0]               chan_done_o;
  logic [NumChannels*(DataWidth-1)-1:0] exit_code_o;
  logic [ChIdxWidth-1:0]                first_chan_o;
  logic [CntWidth-1:0]                  cycles_o;

  modport master (
    output arm_i, mode_i, chan_en_i, timeout_i, wr_valid_i, wr_data_i,
    input  busy_o, done_o, timeout_o, pass_o, chan_done_o, exit_code_o,
           first_chan_o, cycles_o
  );

  modport slave (
    input  arm_i, mode_i, chan_en_i, timeout_i, wr_valid_i, wr_data_i,
    output busy_o, done_o, timeout_o, pass_o, chan_done_o, exit_code_o,
           first_chan_o, cycles_o
  );

endinterface

// File: rtl/eoc_monitor_channel.sv
// One EOC channel: latches the first exit code written with the done bit set.
// Latency: new_o is combinational in the write cycle, done/code visible next cycle; no backpressure.
module eoc_channel
  import iguana_eoc_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 sample_i,
  input  logic                 wr_valid_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 done_o,
  output logic [DataWidth-2:0] code_o,
  output logic                 new_o
);

  logic                 done_q;
  logic [DataWidth-2:0] code_q;

  // Once done, later writes are dropped so the first reported code wins.
  assign new_o = sample_i & wr_valid_i & wr_data_i[DoneBit] & ~done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      code_q <= '0;
    end else if (clear_i) begin
      done_q <= 1'b0;
      code_q <= '0;
    end else if (new_o) begin
      done_q <= 1'b1;
      code_q <= wr_data_i[DataWidth-1:1];
    end
  end

  assign done_o = done_q;
  assign code_o = code_q;

endmodule

// File: rtl/eoc_monitor.sv
// N-channel end-of-computation monitor with ALL/ANY completion and cycle watchdog.
// Latency: status registered, visible the cycle after the completing write; no backpressure.
module eoc_monitor
  import iguana_eoc_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int DataWidth   = 32,
  parameter int CntWidth    = 32,
  parameter int ChIdxWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  eoc_monitor_if.slave bus
);

  eoc_state_e             state_q, state_d;
  logic                   mode_q;
  logic [NumChannels-1:0] en_q;
  logic [CntWidth-1:0]    timeout_q;
  logic [CntWidth-1:0]    cycles_q;
  logic [CntWidth-1:0]    cycles_inc;
  logic [ChIdxWidth-1:0]  first_q;
  logic [ChIdxWidth-1:0]  first_d;

  logic [NumChannels-1:0] done_vec;
  logic [NumChannels-1:0] new_vec;
  logic [NumChannels-1:0] done_next;
  logic [DataWidth-2:0]   code_vec [NumChannels];

  logic run;
  logic arm_ok;
  logic complete;
  logic timeout_hit;
  logic pass_ok;

  assign run    = (state_q == EocRun);
  assign arm_ok = bus.arm_i & ~run;

  for (genvar k = 0; k < NumChannels; k++) begin : g_ch
    eoc_channel #(.DataWidth(DataWidth)) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (arm_ok),
      .sample_i   (run & en_q[k]),
      .wr_valid_i (bus.wr_valid_i[k]),
      .wr_data_i  (bus.wr_data_i[k*DataWidth +: DataWidth]),
      .done_o     (done_vec[k]),
      .code_o     (code_vec[k]),
      .new_o      (new_vec[k])
    );
    assign bus.exit_code_o[k*(DataWidth-1) +: (DataWidth-1)] = code_vec[k];
  end

  always_comb begin
    done_next   = done_vec | new_vec;
    complete    = (mode_q == EocModeAny) ? (|done_next) : ((en_q & done_next) == en_q);
    cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
    timeout_hit = (timeout_q != '0) && (CntWidth'(cycles_q + 1'b1) == timeout_q);
    first_d     = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      if (new_vec[k]) first_d = ChIdxWidth'(k);
    end
    // Non-enabled channels never complete, so only latched codes matter here.
    pass_ok = 1'b1;
    for (int k = 0; k < NumChannels; k++) begin
      if (done_vec[k] && (code_vec[k] != '0)) pass_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EocIdle, EocDone, EocTimeout: begin
        if (bus.arm_i) state_d = (bus.chan_en_i == '0) ? EocDone : EocRun;
      end
      EocRun: begin
        if (complete)         state_d = EocDone;
        else if (timeout_hit) state_d = EocTimeout;
      end
      default: state_d = EocIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EocIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q    <= EocModeAll;
      en_q      <= '0;
      timeout_q <= '0;
      cycles_q  <= '0;
      first_q   <= '0;
    end else if (arm_ok) begin
      mode_q    <= bus.mode_i;
      en_q      <= bus.chan_en_i;
      timeout_q <= bus.timeout_i;
      cycles_q  <= '0;
      first_q   <= '0;
    end else if (run) begin
      cycles_q <= cycles_inc;
      if ((|new_vec) && !(|done_vec)) first_q <= first_d;
    end
  end

  assign bus.busy_o       = (state_q == EocRun);
  assign bus.done_o       = (state_q == EocDone);
  assign bus.timeout_o    = (state_q == EocTimeout);
  assign bus.pass_o       = (state_q == EocDone) & pass_ok;
  assign bus.chan_done_o  = done_vec;
  assign bus.first_chan_o = first_q;
  assign bus.cycles_o     = cycles_q;

endmodule
